// File: rtl/store_scheduler.sv
// Store scheduler: round-robin pick among finished store stations, in-order FIFO,
// and a req/ack write port to data memory that reports each retired RB index.
module store_scheduler #(
  parameter int STORER_NUM = 2,
  parameter int WORD_SIZE  = 32,
  parameter int RB_INDEX   = 4,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [STORER_NUM-1:0]            st_valid,
  input  logic [STORER_NUM*WORD_SIZE-1:0]  st_addr,
  input  logic [STORER_NUM*WORD_SIZE-1:0]  st_data,
  input  logic [STORER_NUM*RB_INDEX-1:0]   st_rb,
  output logic [STORER_NUM-1:0]            st_grant,
  output logic                             mem_req,
  output logic [WORD_SIZE-1:0]             mem_addr,
  output logic [WORD_SIZE-1:0]             mem_data,
  input  logic                             mem_ack,
  output logic                             done_valid,
  output logic [RB_INDEX-1:0]              done_rb,
  output logic [CNT_W-1:0]                 count,
  output logic                             full,
  output logic                             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (STORER_NUM > 1) ? $clog2(STORER_NUM) : 1;

  typedef struct packed {
    logic [WORD_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] data;
    logic [RB_INDEX-1:0]  rb;
  } st_ent_t;

  typedef enum logic {IDLE, REQ} state_t;

  st_ent_t              ent [STORER_NUM];
  st_ent_t              fifo [DEPTH];
  logic [AW-1:0]        head, tail;
  logic [PW-1:0]        ptr, sel, gidx;
  logic                 found, push, pop, load;
  logic [RB_INDEX-1:0]  rb_q;
  state_t               state, state_n;

  for (genvar i = 0; i < STORER_NUM; i++) begin : g_unpack
    assign ent[i] = '{addr: st_addr[i*WORD_SIZE +: WORD_SIZE],
                      data: st_data[i*WORD_SIZE +: WORD_SIZE],
                      rb:   st_rb[i*RB_INDEX +: RB_INDEX]};
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Scan from the rotating pointer; full is registered, so a same-cycle pop never frees a slot.
  always_comb begin
    st_grant = '0;
    gidx     = '0;
    sel      = '0;
    found    = 1'b0;
    for (int k = 0; k < STORER_NUM; k++) begin
      sel = PW'((int'(ptr) + k) % STORER_NUM);
      if (!found && st_valid[sel]) begin
        found = 1'b1;
        gidx  = sel;
      end
    end
    if (found && !full && reset) st_grant[gidx] = 1'b1;
  end

  assign push = |(st_valid & st_grant);

  always_comb begin
    state_n = state;
    load    = 1'b0;
    pop     = 1'b0;
    case (state)
      IDLE: if (!empty) begin state_n = REQ; load = 1'b1; end
      REQ:  if (mem_ack) begin state_n = IDLE; pop = 1'b1; end
      default: state_n = IDLE;
    endcase
  end

  // Storage needs no reset: entries are only visible through count/head.
  always_ff @(posedge clk) begin
    if (push) fifo[tail] <= ent[gidx];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      rb_q       <= '0;
      done_valid <= 1'b0;
      done_rb    <= '0;
    end else begin
      state      <= state_n;
      mem_req    <= (state_n == REQ);
      done_valid <= pop;
      if (push) begin
        tail <= tail + AW'(1);
        ptr  <= PW'((int'(gidx) + 1) % STORER_NUM);
      end
      if (pop) begin
        head    <= head + AW'(1);
        done_rb <= rb_q;
      end
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (load) begin
        mem_addr <= fifo[head].addr;
        mem_data <= fifo[head].data;
        rb_q     <= fifo[head].rb;
      end
    end
  end
endmodule

// File: tb/tb_store_scheduler.sv
// Scoreboard bench for store_scheduler: accepted stores are queued here and
// matched against each memory handshake and the following done pulse.
module tb_store_scheduler;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  st_valid = '0;
  logic [31:0] sa [2];
  logic [31:0] sd [2];
  logic [3:0]  sr [2];
  logic [63:0] st_addr, st_data;
  logic [7:0]  st_rb;
  logic [1:0]  st_grant;
  logic        mem_req, mem_ack = 1'b0, done_valid, full, empty;
  logic [31:0] mem_addr, mem_data;
  logic [3:0]  done_rb;
  logic [2:0]  count;

  typedef struct {logic [31:0] a; logic [31:0] d; logic [3:0] r;} exp_t;
  exp_t sb [$];
  int   total = 0, bad = 0;
  logic pend = 1'b0;
  logic [3:0] pend_rb = '0;

  assign st_addr = {sa[1], sa[0]};
  assign st_data = {sd[1], sd[0]};
  assign st_rb   = {sr[1], sr[0]};

  store_scheduler dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_addr(st_addr),
    .st_data(st_data), .st_rb(st_rb), .st_grant(st_grant), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
    .done_valid(done_valid), .done_rb(done_rb), .count(count), .full(full),
    .empty(empty)
  );

  always #5 clk = ~clk;

  // Memory-side scoreboard: handshakes pop expected stores, done pulse follows one cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) pend = 1'b0;
    else begin
      total++;
      if (done_valid !== pend || (pend && done_rb !== pend_rb)) begin
        bad++;
        $display("FAIL done_pulse: got v=%b rb=%0d want v=%b rb=%0d", done_valid, done_rb, pend, pend_rb);
      end
      pend = 1'b0;
      if (mem_req === 1'b1 && mem_ack === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL mem_write: unexpected write addr=%h data=%h", mem_addr, mem_data);
        end else begin
          e = sb.pop_front();
          if (mem_addr !== e.a || mem_data !== e.d) begin
            bad++;
            $display("FAIL mem_write: got %h/%h want %h/%h", mem_addr, mem_data, e.a, e.d);
          end
          pend = 1'b1;
          pend_rb = e.r;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_st(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] r);
    sa[i] = a; sd[i] = d; sr[i] = r;
  endtask

  task automatic push_exp(input int i);
    sb.push_back('{a: sa[i], d: sd[i], r: sr[i]});
  endtask

  task automatic do_reset();
    cyc();
    reset = 1'b0; st_valid = '0; mem_ack = 1'b0; sb.delete();
    repeat (2) cyc();
    reset = 1'b1;
  endtask

  task automatic drain(input string name);
    mem_ack = 1'b1;
    for (int n = 0; n < 60; n++) begin
      cyc();
      if (sb.size() == 0 && count == 0) break;
    end
    mem_ack = 1'b0;
    total++;
    if (sb.size() != 0 || count !== 3'd0) begin
      bad++;
      $display("FAIL %s_drain: left=%0d count=%0d want 0/0", name, sb.size(), count);
    end
    repeat (2) cyc();
  endtask

  task automatic test_reset();
    set_st(0, 32'h1, 32'h2, 4'h1); set_st(1, 32'h3, 32'h4, 4'h2);
    st_valid = 2'b11;
    #2;
    total++;
    if (mem_req !== 1'b0 || mem_addr !== '0 || mem_data !== '0 || done_valid !== 1'b0 ||
        done_rb !== '0 || count !== '0 || empty !== 1'b1 || full !== 1'b0 || st_grant !== 2'b00) begin
      bad++;
      $display("FAIL reset_state: req=%b addr=%h data=%h dv=%b rb=%0d cnt=%0d e=%b f=%b g=%b want all zero, empty=1",
               mem_req, mem_addr, mem_data, done_valid, done_rb, count, empty, full, st_grant);
    end
    st_valid = '0;
    cyc(); reset = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    cyc();
    set_st(0, 32'h10, 32'hAB, 4'd3); st_valid = 2'b01; #1;
    total++;
    if (st_grant !== 2'b01) begin bad++; $display("FAIL single_grant: got %b want 01", st_grant); end
    push_exp(0);
    cyc(); st_valid = '0; #1;
    total++;
    if (count !== 3'd1 || mem_req !== 1'b0) begin
      bad++; $display("FAIL single_accept: count=%0d req=%b want 1/0", count, mem_req);
    end
    cyc(); #1;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_data !== 32'hAB) begin
      bad++; $display("FAIL single_req: req=%b %h/%h want 1 00000010/000000ab", mem_req, mem_addr, mem_data);
    end
    repeat (2) cyc();
    cyc(); mem_ack = 1'b1;
    cyc(); mem_ack = 1'b0; #1;
    total++;
    if (done_valid !== 1'b1 || done_rb !== 4'd3 || mem_req !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin
      bad++; $display("FAIL single_done: dv=%b rb=%0d req=%b cnt=%0d e=%b want 1 3 0 0 1",
                      done_valid, done_rb, mem_req, count, empty);
    end
    cyc(); #1;
    total++;
    if (done_valid !== 1'b0) begin bad++; $display("FAIL single_pulse_len: dv=%b want 0", done_valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    cyc();
    set_st(0, 32'h200, 32'h1111, 4'd1); set_st(1, 32'h204, 32'h2222, 4'd2);
    st_valid = 2'b11; #1;
    total++;
    if (st_grant !== 2'b01) begin bad++; $display("FAIL rr_grant0: got %b want 01", st_grant); end
    push_exp(0);
    cyc(); st_valid = 2'b10; #1;
    total++;
    if (st_grant !== 2'b10) begin bad++; $display("FAIL rr_grant1: got %b want 10", st_grant); end
    push_exp(1);
    cyc(); set_st(0, 32'h208, 32'h3333, 4'd4); set_st(1, 32'h20C, 32'h4444, 4'd5);
    st_valid = 2'b11; #1;
    total++;
    if (st_grant !== 2'b01) begin bad++; $display("FAIL rr_grant2: got %b want 01", st_grant); end
    push_exp(0);
    cyc(); st_valid = 2'b10; #1;
    total++;
    if (st_grant !== 2'b10) begin bad++; $display("FAIL rr_grant3: got %b want 10", st_grant); end
    push_exp(1);
    cyc(); st_valid = '0; #1;
    total++;
    if (count !== 3'd4 || full !== 1'b1) begin
      bad++; $display("FAIL rr_count: cnt=%0d full=%b want 4/1", count, full);
    end
    drain("rr");
  endtask

  task automatic test_full();
    do_reset();
    cyc();
    for (int k = 0; k < 4; k++) begin
      set_st(0, 32'h100 + 32'(k * 4), 32'hD000 + 32'(k), 4'(k + 8)); st_valid = 2'b01; #1;
      total++;
      if (st_grant !== 2'b01) begin bad++; $display("FAIL full_fill_grant%0d: got %b want 01", k, st_grant); end
      push_exp(0);
      cyc();
    end
    set_st(0, 32'h1F0, 32'hEEEE, 4'd14); #1;
    total++;
    if (count !== 3'd4 || full !== 1'b1 || st_grant !== 2'b00) begin
      bad++; $display("FAIL full_block: cnt=%0d full=%b g=%b want 4 1 00", count, full, st_grant);
    end
    mem_ack = 1'b1;
    cyc(); mem_ack = 1'b0; #1;
    total++;
    if (full !== 1'b0 || count !== 3'd3 || st_grant !== 2'b01) begin
      bad++; $display("FAIL full_release: full=%b cnt=%0d g=%b want 0 3 01", full, count, st_grant);
    end
    push_exp(0);
    cyc(); st_valid = '0; #1;
    total++;
    if (count !== 3'd4) begin bad++; $display("FAIL full_refill: cnt=%0d want 4", count); end
    drain("full");
  endtask

  task automatic test_stall();
    do_reset();
    cyc();
    set_st(0, 32'h300, 32'hCAFE, 4'd5); st_valid = 2'b01; push_exp(0);
    cyc(); st_valid = '0;
    cyc();
    for (int n = 0; n < 10; n++) begin
      #1;
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h300 || mem_data !== 32'hCAFE || done_valid !== 1'b0) begin
        bad++; $display("FAIL stall_hold%0d: req=%b %h/%h dv=%b want 1 00000300/0000cafe 0",
                        n, mem_req, mem_addr, mem_data, done_valid);
      end
      cyc();
    end
    drain("stall");
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc();
    set_st(0, 32'h400, 32'h5, 4'd6); st_valid = 2'b01; push_exp(0);
    cyc(); set_st(1, 32'h404, 32'h6, 4'd7); st_valid = 2'b10; push_exp(1);
    cyc(); st_valid = '0; #1;
    total++;
    if (mem_req !== 1'b1 || count !== 3'd2) begin
      bad++; $display("FAIL rstmid_pre: req=%b cnt=%0d want 1/2", mem_req, count);
    end
    cyc(); reset = 1'b0; sb.delete(); #1;
    total++;
    if (mem_req !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || done_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid_async: req=%b cnt=%0d e=%b dv=%b want 0 0 1 0", mem_req, count, empty, done_valid);
    end
    repeat (2) cyc();
    reset = 1'b1;
    for (int n = 0; n < 5; n++) begin
      cyc(); #1;
      total++;
      if (mem_req !== 1'b0 || done_valid !== 1'b0) begin
        bad++; $display("FAIL rstmid_idle%0d: req=%b dv=%b want 0/0", n, mem_req, done_valid);
      end
    end
  endtask

  task automatic test_spurious_ack();
    do_reset();
    cyc(); mem_ack = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cyc(); #1;
      total++;
      if (done_valid !== 1'b0 || count !== 3'd0 || mem_req !== 1'b0) begin
        bad++; $display("FAIL spurious_ack%0d: dv=%b cnt=%0d req=%b want 0 0 0", n, done_valid, count, mem_req);
      end
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_stall();
    test_reset_mid();
    test_spurious_ack();
    repeat (2) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/store_scheduler.md
# store_scheduler

Serialises completed stores from `STORER_NUM` store reservation stations onto the single data-memory write port. It arbitrates round-robin among stations presenting a finished store (address, data, reorder-buffer index) and queues accepted stores in a `DEPTH`-entry in-order FIFO. It drives a req/ack write handshake to memory and reports each retired store's RB index back to the reorder buffer.

## Interface
- `STORER_NUM`, default 2: number of store reservation stations.
- `WORD_SIZE`, default 32: address/data width.
- `RB_INDEX`, default 4: reorder-buffer index width.
- `DEPTH`, default 4: FIFO entries, power of two, ≥2.
- `CNT_W`, default $clog2(DEPTH)+1: occupancy counter width.
---
- `clk` in 1: single clock; all state on posedge.
- `reset` in 1: asynchronous, active-low; everything clears while low.
- `st_valid` in STORER_NUM: station i holds a completed store; held until granted.
- `st_addr` in STORER_NUM*WORD_SIZE: slice i = station i address.
- `st_data` in STORER_NUM*WORD_SIZE: slice i = station i data.
- `st_rb` in STORER_NUM*RB_INDEX: slice i = station i RB index.
- `st_grant` out STORER_NUM: one-hot combinational accept; transfer on posedge where `st_valid[i] & st_grant[i]`.
- `mem_req` out 1: write request, registered.
- `mem_addr` out WORD_SIZE: write address, registered.
- `mem_data` out WORD_SIZE: write data, registered.
- `mem_ack` in 1: memory accepted the write; sampled only while `mem_req`=1.
- `done_valid` out 1: one-cycle pulse, store retired.
- `done_rb` out RB_INDEX: RB index of the retired store.
- `count` out CNT_W: FIFO occupancy.
- `full` out 1: count==DEPTH.
- `empty` out 1: count==0.

## Operation
- Reset values: mem_req=0, mem_addr=0, mem_data=0, done_valid=0, done_rb=0, count=0, empty=1, full=0, rr pointer=0, state=IDLE. st_grant forced 0 while reset low.
- Arbitration: when !full, grant the first valid station scanning from pointer p upward, mod STORER_NUM. At most one grant per cycle. After granting station i, p←(i+1) mod STORER_NUM. No grant, pointer unchanged. When full, all grants 0.
- Enqueue: on a granted transfer, write {addr, data, rb} at tail; tail wraps mod DEPTH.
- FSM IDLE: if !empty at posedge → REQ; load mem_addr/mem_data/internal rb from head; mem_req←1.
- FSM REQ: hold mem_req, mem_addr and mem_data stable. On posedge with mem_ack=1: pop head, mem_req←0, done_valid←1, done_rb←head rb, → IDLE.
- done_valid is 0 in every other cycle.
- Simultaneous push and pop: count unchanged; both pointers advance.
- full is registered state, so a pop does not enable a grant in the same cycle.
- mem_ack while mem_req=0 is ignored.
- Memory order equals acceptance order.

## Timing
- Accept at edge E (empty FIFO, IDLE) → state REQ at edge E+1 → mem_req high during the cycle after E+1.
- Ack sampled at edge A → during the cycle after A: done_valid=1, mem_req=0.
- Earliest next mem_req: the cycle after the state returns to IDLE, giving a one-cycle gap between consecutive requests.
- Peak throughput: one store per 2 cycles plus memory wait.
- Reset asserted mid-operation: mem_req drops asynchronously, FIFO contents are discarded, and an outstanding write is abandoned with no done pulse. After release, nothing is issued until a new store is accepted.

## Test plan
- Single store: station 0 presents addr 0x10, data 0xAB, rb 3 → st_grant=01 that cycle. mem_req rises 2 cycles later with 0x10/0xAB. Ack after 3 cycles → one-cycle done_valid with done_rb=3; count=0, empty=1.
- Round-robin: both stations valid after reset → grants 01 then 10. Memory writes occur in station 0, then station 1 order. Both valid again → grant 01.
- Full: mem_ack held 0 while 4 stores are pushed → count=4, full=1, 5th station sees grant 0. One ack → full=0 next cycle, 5th store accepted the cycle after.
- Stall: mem_ack low for 10 cycles in REQ → mem_req, mem_addr and mem_data constant; no done pulse.
- Reset mid-REQ with 2 entries queued → mem_req=0 immediately, count=0, done_valid never pulses. After release and idle cycles, mem_req stays 0.
- Spurious mem_ack=1 in IDLE with empty FIFO → no done_valid, count stays 0.
